// File: rtl/urv_typedef.sv
// Shared core typedefs: mem protocol bundles plus AHB-Lite constants.
// ahb_mask() gives byte mask and misalignment flag for an AHB beat.
package urv_typedef;

  localparam int XLEN = 32;
  localparam int MASK_W = XLEN / 8;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    logic [XLEN-1:0]   req_addr;
    mem_type_e         req_type;
    logic [MASK_W-1:0] req_mask;
    logic [XLEN-1:0]   req_data;
    logic [3:0]        req_burst;
  } mem_req_t;

  typedef struct packed {
    logic [XLEN-1:0] resp_data;
  } mem_resp_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef struct packed {
    logic [3:0] mask;
    logic       misalign;
  } ahb_mask_t;

  // Sizes above a word are reported as misaligned.
  function automatic ahb_mask_t ahb_mask(
    input logic [2:0] hsize,
    input logic [1:0] addr_lsb
  );
    ahb_mask_t r;
    r.mask     = 4'hF;
    r.misalign = 1'b0;
    unique case (1'b1)
      hsize == HSIZE_BYTE:
        r.mask = 4'b0001 << addr_lsb;
      hsize == HSIZE_HALF: begin
        r.mask     = 4'b0011 << {addr_lsb[1], 1'b0};
        r.misalign = addr_lsb[0];
      end
      hsize == HSIZE_WORD:
        r.misalign = |addr_lsb;
      default:
        r.misalign = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb2mem.sv
// AHB-Lite slave -> mem valid/ready bridge, one outstanding access.
// Ports: AHB slave (h*), mem request (mem_req*), mem response (mem_resp*).
module ahb2mem
  import urv_typedef::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter bit ERR_ON_UNALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    hsel,
  input  logic [1:0]              htrans,
  input  logic [2:0]              hburst,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [2:0]              hsize,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic                    hwrite,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hresp,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output mem_req_t                mem_req,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  mem_resp_t               mem_resp
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [MW-1:0]         mask_q;

  logic      cap;
  logic      bad;
  logic [1:0] lsb;
  ahb_mask_t mk;

  logic unused;
  assign unused = ^{hburst, htrans[0]};

  // Only accept an address phase while our own data phase is not stalled.
  assign cap = hsel & hready & htrans[1] & hreadyout;

  always_comb begin
    lsb = haddr[1:0];
    if (!ERR_ON_UNALIGNED) begin
      unique case (1'b1)
        hsize == HSIZE_BYTE: lsb = haddr[1:0];
        hsize == HSIZE_HALF: lsb = {haddr[1], 1'b0};
        default:             lsb = 2'b00;
      endcase
    end
    mk  = ahb_mask(hsize, lsb);
    bad = ERR_ON_UNALIGNED ? mk.misalign
                           : (hsize > HSIZE_WORD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hreadyout      = 1'b1;
    hresp          = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        hresp = (state == ST_ERR2);
        if (cap) begin
          state_nxt = bad ? ST_ERR1 : ST_REQ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        hreadyout     = 1'b0;
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        hreadyout      = 1'b0;
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          state_nxt = ST_DONE;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      mask_q  <= '0;
    end else if (cap) begin
      addr_q  <= {haddr[ADDR_WIDTH-1:2], lsb};
      write_q <= hwrite;
      mask_q  <= mk.mask;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hrdata <= '0;
    end else if (state == ST_RESP && mem_resp_valid && !write_q) begin
      hrdata <= mem_resp.resp_data;
    end
  end

  // hwdata is held by the master for the whole stretched data phase.
  always_comb begin
    mem_req.req_addr  = addr_q;
    mem_req.req_type  = write_q ? MEM_WRITE : MEM_READ;
    mem_req.req_mask  = write_q ? mask_q : '1;
    mem_req.req_data  = hwdata;
    mem_req.req_burst = 4'd1;
  end

endmodule

// File: tb/tb_ahb2mem.sv
// Directed bench for ahb2mem with a word-array mem target model.
// Table vectors plus hand sequences for back-pressure, b2b and reset.
module tb_ahb2mem;
  import urv_typedef::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hwrite;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;
  logic        mem_req_valid;
  logic        mem_req_ready;
  mem_req_t    mem_req;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  mem_resp_t   mem_resp;

  always #5 clk = ~clk;

  assign hready = hreadyout;

  ahb2mem dut (
    .clk            (clk),
    .rstn           (rstn),
    .hsel           (hsel),
    .htrans         (htrans),
    .hburst         (hburst),
    .haddr          (haddr),
    .hsize          (hsize),
    .hwdata         (hwdata),
    .hwrite         (hwrite),
    .hready         (hready),
    .hreadyout      (hreadyout),
    .hrdata         (hrdata),
    .hresp          (hresp),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req        (mem_req),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp       (mem_resp)
  );

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Target model: ready after req_wait valid cycles, response
  // resp_wait cycles after the first response-pending cycle.
  int          req_wait = 0;
  int          resp_wait = 0;
  int          rq_cnt;
  int          rs_cnt;
  bit          busy;
  logic [31:0] rs_data;
  logic [31:0] mem [64];

  assign mem_req_ready = mem_req_valid && !busy && rq_cnt >= req_wait;
  assign mem_resp_valid = busy && rs_cnt >= resp_wait;
  assign mem_resp.resp_data = rs_data;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rq_cnt  <= 0;
      rs_cnt  <= 0;
      busy    <= 1'b0;
      rs_data <= '0;
      for (int i = 0; i < 64; i++) begin
        mem[i] <= 32'hC0DE_0000 | (i * 4);
      end
    end else begin
      if (mem_req_valid && !busy) begin
        if (mem_req_ready) begin
          busy   <= 1'b1;
          rs_cnt <= 0;
          rq_cnt <= 0;
          rs_data <= mem[mem_req.req_addr[7:2]];
          if (mem_req.req_type == MEM_WRITE) begin
            for (int b = 0; b < 4; b++) begin
              if (mem_req.req_mask[b]) begin
                mem[mem_req.req_addr[7:2]][8*b +: 8] <=
                  mem_req.req_data[8*b +: 8];
              end
            end
          end
        end else begin
          rq_cnt <= rq_cnt + 1;
        end
      end
      if (busy) begin
        if (mem_resp_valid && mem_resp_ready) begin
          busy <= 1'b0;
        end else begin
          rs_cnt <= rs_cnt + 1;
        end
      end
    end
  end

  // Request log, valid-cycle count and stability of stalled requests.
  mem_req_t log_q[$];
  int       vcycles = 0;
  bit       stalled = 1'b0;
  mem_req_t held;

  always @(negedge clk) begin
    if (!rstn) begin
      stalled = 1'b0;
    end else begin
      if (mem_req_valid) vcycles++;
      if (mem_req_valid && stalled) begin
        chk("req_stable", 32'(mem_req != held), 32'd0);
      end
      if (mem_req_valid && mem_req_ready) log_q.push_back(mem_req);
      stalled = mem_req_valid && !mem_req_ready;
      held    = mem_req;
    end
  end

  task automatic wait_rdy(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hreadyout) break;
    end
    if (!hreadyout) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic xfer(input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int waits, output int vc);
    int v0;
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr  = a;
    hsize  = sz;
    hwrite = w;
    wait_rdy("addr");
    v0 = vcycles;
    @(posedge clk); #1;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = wd;
    waits  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hreadyout) break;
      waits++;
    end
    if (!hreadyout) chk("data_timeout", 32'd0, 32'd1);
    rd = hrdata;
    er = hresp;
    vc = vcycles - v0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  mask;
    logic        err;
  } vec_t;

  vec_t tv [12];

  function automatic vec_t mk(input logic w, input logic [2:0] sz,
                              input logic [31:0] a,
                              input logic [31:0] wd,
                              input logic [31:0] rd,
                              input logic [3:0] m, input logic e);
    vec_t v;
    v.w = w; v.sz = sz; v.a = a; v.wd = wd;
    v.rd = rd; v.mask = m; v.err = e;
    return v;
  endfunction

  logic [31:0] rd;
  logic        er;
  int          waits;
  int          vc;
  int          n0;
  mem_req_t    r;

  initial begin
    tv[0]  = mk(1, HSIZE_WORD, 32'h10, 32'h1234_5678, 0, 4'hF, 0);
    tv[1]  = mk(0, HSIZE_WORD, 32'h10, 0, 32'h1234_5678, 4'hF, 0);
    tv[2]  = mk(1, HSIZE_BYTE, 32'h13, 32'hAB00_0000, 0, 4'h8, 0);
    tv[3]  = mk(1, HSIZE_HALF, 32'h16, 32'hCDEF_0000, 0, 4'hC, 0);
    tv[4]  = mk(0, HSIZE_WORD, 32'h10, 0, 32'hAB34_5678, 4'hF, 0);
    tv[5]  = mk(0, HSIZE_WORD, 32'h14, 0, 32'hCDEF_0014, 4'hF, 0);
    tv[6]  = mk(1, HSIZE_WORD, 32'h11, 32'hDEAD_BEEF, 0, 4'h0, 1);
    tv[7]  = mk(0, HSIZE_HALF, 32'h13, 0, 0, 4'h0, 1);
    tv[8]  = mk(0, HSIZE_WORD, 32'h10, 0, 32'hAB34_5678, 4'hF, 0);
    tv[9]  = mk(0, HSIZE_BYTE, 32'h12, 0, 32'hAB34_5678, 4'hF, 0);
    tv[10] = mk(1, 3'd3, 32'h18, 32'h5555_5555, 0, 4'h0, 1);
    tv[11] = mk(1, HSIZE_BYTE, 32'h19, 32'h0000_7700, 0, 4'h2, 0);

    rstn = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE;
    hburst = 3'd0; haddr = '0; hsize = HSIZE_WORD;
    hwdata = '0; hwrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_resp_ready", 32'(mem_resp_ready), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      n0 = log_q.size();
      xfer(tv[i].w, tv[i].sz, tv[i].a, tv[i].wd, rd, er, waits, vc);
      chk($sformatf("v%0d_hresp", i), 32'(er), 32'(tv[i].err));
      chk($sformatf("v%0d_waits", i), waits, tv[i].err ? 1 : 2);
      if (tv[i].err) begin
        chk($sformatf("v%0d_noreq", i), vc, 0);
      end else begin
        chk($sformatf("v%0d_nreq", i), log_q.size() - n0, 1);
        if (log_q.size() > n0) begin
          r = log_q[n0];
          chk($sformatf("v%0d_addr", i), r.req_addr, tv[i].a);
          chk($sformatf("v%0d_type", i), 32'(r.req_type),
              32'(tv[i].w));
          chk($sformatf("v%0d_mask", i), 32'(r.req_mask),
              32'(tv[i].mask));
          chk($sformatf("v%0d_burst", i), 32'(r.req_burst), 32'd1);
          if (tv[i].w) begin
            chk($sformatf("v%0d_wdata", i), r.req_data, tv[i].wd);
          end else begin
            chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
          end
        end
      end
    end

    // Back-pressure: 5 refused request cycles, response 3 cycles
    // after acceptance -> 9 stalled data-phase cycles.
    req_wait = 5; resp_wait = 2;
    n0 = log_q.size();
    xfer(1, HSIZE_WORD, 32'h1C, 32'h5A5A_A5A5, rd, er, waits, vc);
    chk("bp_waits", waits, 9);
    chk("bp_vcycles", vc, 6);
    chk("bp_hresp", 32'(er), 32'd0);
    if (log_q.size() > n0) chk("bp_data", log_q[n0].req_data,
                               32'h5A5A_A5A5);
    else chk("bp_nreq", log_q.size() - n0, 1);
    req_wait = 0; resp_wait = 0;
    xfer(0, HSIZE_WORD, 32'h1C, 0, rd, er, waits, vc);
    chk("bp_readback", rd, 32'h5A5A_A5A5);

    // Back-to-back reads, then IDLE/BUSY/deselected cycles.
    n0 = log_q.size();
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0;
    hsize = HSIZE_WORD; haddr = 32'h0;
    wait_rdy("b2b_a");
    @(posedge clk); #1;
    haddr = 32'h4;
    wait_rdy("b2b_b");
    chk("b2b_rd0", hrdata, 32'hC0DE_0000);
    chk("b2b_hresp0", 32'(hresp), 32'd0);
    @(posedge clk); #1;
    htrans = HTRANS_IDLE;
    wait_rdy("b2b_c");
    chk("b2b_rd1", hrdata, 32'hC0DE_0004);
    @(posedge clk); #1;
    htrans = HTRANS_BUSY; haddr = 32'h30;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = HTRANS_IDLE;
    @(posedge clk); #1;
    hsel = 1'b0;
    xfer(0, HSIZE_WORD, 32'h8, 0, rd, er, waits, vc);
    chk("b2b_rd2", rd, 32'hC0DE_0008);
    chk("b2b_nreq", log_q.size() - n0, 3);
    if (log_q.size() - n0 == 3) begin
      chk("b2b_addr0", log_q[n0].req_addr, 32'h0);
      chk("b2b_addr1", log_q[n0+1].req_addr, 32'h4);
      chk("b2b_addr2", log_q[n0+2].req_addr, 32'h8);
    end

    // Reset while waiting for the response.
    resp_wait = 50;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20;
    hwrite = 1'b0; hsize = HSIZE_WORD;
    wait_rdy("rst_addr");
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_resp_ready) break;
    end
    chk("mid_in_resp", 32'(mem_resp_ready), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_hreadyout", 32'(hreadyout), 32'd1);
    chk("mid_req_valid", 32'(mem_req_valid), 32'd0);
    chk("mid_hresp", 32'(hresp), 32'd0);
    chk("mid_resp_ready", 32'(mem_resp_ready), 32'd0);
    chk("mid_hrdata", hrdata, 32'd0);
    resp_wait = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    xfer(0, HSIZE_WORD, 32'h20, 0, rd, er, waits, vc);
    chk("post_rst_rd", rd, 32'hC0DE_0020);
    chk("post_rst_hresp", 32'(er), 32'd0);
    chk("post_rst_waits", waits, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/ahb2mem.md
Name: ahb2mem

Overview:
- AHB-Lite slave that converts single-beat AHB transfers into the core's valid/ready memory request/response handshake (mem_req_t / mem_resp_t).
- Mirror of mem2ahb: lets an external AHB master (debug/DMA) reach any mem-protocol target, e.g. ITCM/DTCM or the mem arbiter.
- One outstanding mem transaction at a time; the AHB data phase is stretched with hreadyout until the mem response returns.

Parameters:
- ADDR_WIDTH, 32, haddr and req_addr width
- DATA_WIDTH, 32, hwdata/hrdata/req_data width; mask width is DATA_WIDTH/8
- ERR_ON_UNALIGNED, 1, when 1 a misaligned access gets a two-cycle ERROR response; when 0 address LSBs are forced to alignment

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- htrans  in  2  transfer type
- hburst  in  3  burst type; ignored, every beat handled as single
- haddr  in  ADDR_WIDTH  address
- hsize  in  3  transfer size; 0=byte, 1=half, 2=word
- hwdata  in  DATA_WIDTH  write data, data phase
- hwrite  in  1  1=write
- hready  in  1  bus-wide ready
- hreadyout  out  1  slave ready
- hrdata  out  DATA_WIDTH  read data
- hresp  out  1  0=OKAY, 1=ERROR
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request accepted
- mem_req  out  mem_req_t  req_addr, req_type, req_mask, req_data, req_burst
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  response accept
- mem_resp  in  mem_resp_t  resp_data

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: hreadyout=1, hresp=0, hrdata=0, mem_req_valid=0, mem_resp_ready=0; FSM in IDLE; captured address/control registers cleared.
- Address-phase capture: when hsel & hready & htrans[1] (NONSEQ or SEQ), register haddr, hsize, hwrite, the computed mask and an error flag. IDLE and BUSY never start a transaction.
- Mask generation:
  - byte: 1<<haddr[1:0]
  - half: 0x3<<{haddr[1],1'b0}
  - word: 0xF
- Misalignment is half with haddr[0]=1, or word with haddr[1:0]!=0. hsize>2 is also an error.
- FSM states:
  - IDLE: hreadyout=1. On capture, go to REQ, or to ERR1 if the error flag is set.
  - REQ: mem_req_valid=1, hreadyout=0.
    - req_addr = captured addr.
    - req_type = MEM_WRITE / MEM_READ.
    - req_mask = captured mask; reads use all-ones.
    - req_data = hwdata, driven live; it is stable because the AHB data phase is held.
    - req_burst = 1.
    - Hold all fields stable until mem_req_ready; on ready, go to RESP.
  - RESP: mem_resp_ready=1, hreadyout=0. On mem_resp_valid, register hrdata <= resp_data (reads only; writes leave hrdata unchanged), then go to DONE.
  - DONE: hreadyout=1, hresp=0 for one cycle. A new capture in this cycle goes directly to REQ/ERR1 (back-to-back); otherwise go to IDLE.
  - ERR1: hresp=1, hreadyout=0. Next state is ERR2.
  - ERR2: hresp=1, hreadyout=1. A capture in this cycle is honoured; otherwise go to IDLE. No mem request is issued for errored transfers.
- Latency: address phase at T0, mem_req_valid at T1. With ready at T1 and resp_valid at T2, hreadyout=1 at T3, giving a minimum of 2 wait states.
- Back-pressure:
  - Any number of cycles with mem_req_ready=0 or mem_resp_valid=0 keeps hreadyout=0.
  - mem_req stays constant throughout.
- mem_resp_valid arriving outside RESP is ignored (mem_resp_ready=0).
- Reset mid-transaction immediately forces all reset values. Any in-flight mem transaction is abandoned; the downstream target is reset by the same rstn.

Decomposition:
- urv_typedef (shared package) gains:
  - AHB htrans constants HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - hsize constants HSIZE_BYTE/HALF/WORD.
  - A function ahb_mask(hsize, addr_lsb) returning the byte mask and a misalignment flag. mem2ahb and ahb2mem share it.
- mem_req_t, mem_resp_t, MEM_READ and MEM_WRITE are reused from urv_typedef unchanged.
- No sub-module: a single FSM plus the capture registers.

Test Plan:
- Word write: haddr 0x10, hwdata 0x12345678 -> one mem_req {addr 0x10, MEM_WRITE, mask 0xF, data 0x12345678, burst 1}. Read of 0x10 -> hrdata 0x12345678, hresp 0.
- Byte write 0x13 and half write 0x16 -> masks 0x8 and 0xC; the following word read returns the merged data.
- Unaligned word at 0x11 and half at 0x13 -> two-cycle ERROR (ERR1 then ERR2), zero mem_req_valid cycles. The next legal transfer completes OKAY.
- Back-pressure: mem_req_ready low 5 cycles, then mem_resp_valid delayed 3 cycles -> hreadyout low for exactly 9 cycles, mem_req fields constant.
- Back-to-back NONSEQ reads 0x0, 0x4, 0x8, with IDLE and BUSY cycles and hsel=0 interleaved -> exactly three mem_reqs, in order, with correct data.
- rstn asserted while in RESP -> hreadyout=1, mem_req_valid=0, hresp=0 immediately. After rstn is released, a read of 0x20 completes correctly.
